// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control FSM.
//
// Steps each instruction through fetch, decode, execute, memory and writeback
// for lw, sw, R-type, beq, addi and j. It drives the ALU function and the
// datapath selects and enables, and it reads the ALU zero flag. FETCH, MEMRD
// and MEMWR wait in place until mem_ready is high.
//
// Optional feature: define MIPS_BNE_EN to add bne (opcode 000101, state
// BNEEX = 13). When the macro is undefined, bne is treated as an illegal
// opcode.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   opcode, funct         IR[31:26] and IR[5:0]
//   zero                  ALU zero flag
//   mem_ready             memory access completes this cycle
//   alu_f                 ALU function select
//   alu_src_a, alu_src_b  ALU operand selects
//   pc_src, pc_en         PC next-value select and write enable
//   iord                  memory address select (0=PC, 1=ALUOut)
//   mem_req, mem_write    memory request and write strobe
//   ir_write              IR load enable
//   reg_write, reg_dst    register file write enable and destination select
//   mem_to_reg            register file write data select
//   illegal               one-cycle pulse on an undecodable instruction
//   dbg_state             current state code
//
// state   | meaning
// RESET   | idle while in reset, all outputs low
// FETCH   | read instruction at PC, PC+4 into PC
// DECODE  | opcode dispatch, branch target precompute
// MEMADR  | load/store address computation
// MEMRD   | load data read
// MEMWB   | load data to rt
// MEMWR   | store data write
// RTYPEEX | R-type ALU operation
// RTYPEWB | R-type result to rd
// BEQEX   | beq compare, branch if equal
// ADDIEX  | addi ALU operation
// ADDIWB  | addi result to rt
// JEX     | jump
// BNEEX   | bne compare, branch if not equal (MIPS_BNE_EN only)

module mips_mc_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [2:0]         alu_f,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_req,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  typedef enum logic [STATE_W-1:0] {
    S_RESET   = STATE_W'(0),
    S_FETCH   = STATE_W'(1),
    S_DECODE  = STATE_W'(2),
    S_MEMADR  = STATE_W'(3),
    S_MEMRD   = STATE_W'(4),
    S_MEMWB   = STATE_W'(5),
    S_MEMWR   = STATE_W'(6),
    S_RTYPEEX = STATE_W'(7),
    S_RTYPEWB = STATE_W'(8),
    S_BEQEX   = STATE_W'(9),
    S_ADDIEX  = STATE_W'(10),
    S_ADDIWB  = STATE_W'(11),
    S_JEX     = STATE_W'(12)
`ifdef MIPS_BNE_EN
    ,
    S_BNEEX   = STATE_W'(13)
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_SUB = 3'b110;
  localparam logic [2:0] F_SLT = 3'b111;

  state_t state;

  // funct decode: bit 3 is the valid flag, bits 2:0 are the ALU function.
  // An unknown funct falls back to ADD so the ALU still sees a defined
  // operation during the cycle that raises the illegal pulse.
  function automatic logic [3:0] funct_dec(input logic [5:0] fn);
    case (fn)
      6'b100000: funct_dec = {1'b1, F_ADD};
      6'b100010: funct_dec = {1'b1, F_SUB};
      6'b100100: funct_dec = {1'b1, F_AND};
      6'b100101: funct_dec = {1'b1, F_OR};
      6'b101010: funct_dec = {1'b1, F_SLT};
      default:   funct_dec = {1'b0, F_ADD};
    endcase
  endfunction

  logic [3:0] fdec;
  assign fdec = funct_dec(funct);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_RTYPEEX;
            OP_BEQ:       state <= S_BEQEX;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JEX;
`ifdef MIPS_BNE_EN
            OP_BNE:       state <= S_BNEEX;
`endif
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (opcode == OP_LW)      state <= S_MEMRD;
          else if (opcode == OP_SW) state <= S_MEMWR;
          else                      state <= S_FETCH;
        end
        S_MEMRD:   if (mem_ready) state <= S_MEMWB;
        S_MEMWB:   state <= S_FETCH;
        S_MEMWR:   if (mem_ready) state <= S_FETCH;
        S_RTYPEEX: state <= fdec[3] ? S_RTYPEWB : S_FETCH;
        S_RTYPEWB: state <= S_FETCH;
        S_BEQEX:   state <= S_FETCH;
        S_ADDIEX:  state <= S_ADDIWB;
        S_ADDIWB:  state <= S_FETCH;
        S_JEX:     state <= S_FETCH;
`ifdef MIPS_BNE_EN
        S_BNEEX:   state <= S_FETCH;
`endif
        default:   state <= S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from the state register. The only inputs that reach
  // them are mem_ready (FETCH handshake), zero (branch enable), and
  // opcode/funct (illegal flag and R-type ALU function).
  always_comb begin
    alu_f      = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_f     = F_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_f     = F_ADD;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
`ifdef MIPS_BNE_EN
          OP_BNE:  illegal = 1'b0;
`endif
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_f     = F_ADD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_f     = fdec[2:0];
        illegal   = ~fdec[3];
      end
      S_RTYPEWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_f     = F_SUB;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_f     = F_ADD;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JEX: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
`ifdef MIPS_BNE_EN
      S_BNEEX: begin
        alu_src_a = 1'b1;
        alu_f     = F_SUB;
        pc_src    = 2'b01;
        pc_en     = ~zero;
      end
`endif
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Testbench for mips_mc_ctrl. For every cycle it pushes an expected snapshot
// of the state and all outputs into a queue when it drives the stimulus. It
// pops that snapshot and compares it after the DUT outputs settle on the
// falling edge.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [2:0] alu_f;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_en, iord, mem_req, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0] dbg_state;

  mips_mc_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_f(alu_f), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en), .iord(iord),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [20:0] v;
  } sb_t;
  sb_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Snapshot packing: state, F, src_a, src_b, pc_src, pc_en, iord, mem_req,
  // mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal.
  function automatic logic [20:0] pk(input logic [3:0] st, input logic [2:0] f,
      input logic sa, input logic [1:0] sb, input logic [1:0] ps, input logic pe,
      input logic io, input logic mr, input logic mw, input logic irw,
      input logic rw, input logic rd, input logic m2r, input logic ill);
    return {st, f, sa, sb, ps, pe, io, mr, mw, irw, rw, rd, m2r, ill};
  endfunction

  function automatic logic [20:0] v_reset();
    return 21'd0;
  endfunction
  function automatic logic [20:0] v_fetch(input logic m);
    return pk(4'd1, 3'b010, 0, 2'b01, 2'b00, m, 0, 1, 0, m, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] v_decode(input logic ill);
    return pk(4'd2, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, ill);
  endfunction
  function automatic logic [20:0] v_memadr();
    return pk(4'd3, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] v_memrd();
    return pk(4'd4, 3'b000, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] v_memwb();
    return pk(4'd5, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0);
  endfunction
  function automatic logic [20:0] v_memwr();
    return pk(4'd6, 3'b000, 0, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] v_rtex(input logic [2:0] f, input logic ill);
    return pk(4'd7, f, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, ill);
  endfunction
  function automatic logic [20:0] v_rtwb();
    return pk(4'd8, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0);
  endfunction
  function automatic logic [20:0] v_beq(input logic pe);
    return pk(4'd9, 3'b110, 1, 2'b00, 2'b01, pe, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] v_addiex();
    return pk(4'd10, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] v_addiwb();
    return pk(4'd11, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endfunction
  function automatic logic [20:0] v_j();
    return pk(4'd12, 3'b000, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] v_bne(input logic pe);
    return pk(4'd13, 3'b110, 1, 2'b00, 2'b01, pe, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [20:0] actual();
    return {dbg_state, alu_f, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_req,
            mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal};
  endfunction

  // One cycle: entered just after a rising edge. It drives the inputs, pushes
  // the expected snapshot, compares on the falling edge, then moves on past
  // the next rising edge.
  task automatic step(input logic mr, input logic z, input logic [20:0] e, input string tag);
    sb_t s, got;
    mem_ready = mr;
    zero      = z;
    s.tag = tag;
    s.v   = e;
    sb_q.push_back(s);
    @(negedge clk);
    got = sb_q.pop_front();
    chk(got.tag, {11'd0, actual()}, {11'd0, got.v});
    @(posedge clk);
    #1;
  endtask

  logic [5:0] rt_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [2:0] rt_f  [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0; funct = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, v_reset(), "rst_hold");
    rst_n = 1'b1;
    step(1, 0, v_reset(), "rst_release");

    // R-type: add, sub, and, or, slt
    opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      funct = rt_fn[i];
      step(1, 0, v_fetch(1), "rt_fetch");
      step(1, 0, v_decode(0), "rt_decode");
      step(1, 0, v_rtex(rt_f[i], 0), "rt_ex");
      step(1, 0, v_rtwb(), "rt_wb");
    end

    // lw with a three-cycle memory stall
    opcode = 6'b100011; funct = 6'd0;
    step(1, 0, v_fetch(1), "lw_fetch");
    step(1, 0, v_decode(0), "lw_decode");
    step(1, 0, v_memadr(), "lw_memadr");
    for (int i = 0; i < 3; i++) step(0, 0, v_memrd(), "lw_memrd_stall");
    step(1, 0, v_memrd(), "lw_memrd");
    step(1, 0, v_memwb(), "lw_memwb");

    // sw with one fetch stall cycle
    opcode = 6'b101011;
    step(0, 0, v_fetch(0), "sw_fetch_stall");
    step(1, 0, v_fetch(1), "sw_fetch");
    step(1, 0, v_decode(0), "sw_decode");
    step(1, 0, v_memadr(), "sw_memadr");
    step(1, 0, v_memwr(), "sw_memwr");

    // beq taken and not taken
    opcode = 6'b000100;
    step(1, 0, v_fetch(1), "beq1_fetch");
    step(1, 0, v_decode(0), "beq1_decode");
    step(1, 1, v_beq(1), "beq_taken");
    step(1, 0, v_fetch(1), "beq0_fetch");
    step(1, 0, v_decode(0), "beq0_decode");
    step(1, 0, v_beq(0), "beq_not_taken");

    // j
    opcode = 6'b000010;
    step(1, 0, v_fetch(1), "j_fetch");
    step(1, 0, v_decode(0), "j_decode");
    step(1, 0, v_j(), "j_ex");

    // addi
    opcode = 6'b001000;
    step(1, 0, v_fetch(1), "addi_fetch");
    step(1, 0, v_decode(0), "addi_decode");
    step(1, 0, v_addiex(), "addi_ex");
    step(1, 0, v_addiwb(), "addi_wb");

    // illegal opcode, then illegal funct; the following FETCH shows no write
    opcode = 6'b111111;
    step(1, 0, v_fetch(1), "illop_fetch");
    step(1, 0, v_decode(1), "illop_decode");
    opcode = 6'b000000; funct = 6'b000111;
    step(1, 0, v_fetch(1), "illfn_fetch");
    step(1, 0, v_decode(0), "illfn_decode");
    step(1, 0, v_rtex(3'b010, 1), "illfn_ex");

    // bne with zero=0
    opcode = 6'b000101; funct = 6'd0;
    step(1, 0, v_fetch(1), "bne_fetch");
`ifdef MIPS_BNE_EN
    step(1, 0, v_decode(0), "bne_decode");
    step(1, 0, v_bne(1), "bne_ex");
`else
    step(1, 0, v_decode(1), "bne_illegal");
`endif

    // reset asserted while stalled in MEMRD
    opcode = 6'b100011;
    step(1, 0, v_fetch(1), "rstlw_fetch");
    step(1, 0, v_decode(0), "rstlw_decode");
    step(1, 0, v_memadr(), "rstlw_memadr");
    step(0, 0, v_memrd(), "rstlw_memrd");
    rst_n = 1'b0;
    #1;
    chk("rst_async", {11'd0, actual()}, {11'd0, v_reset()});
    step(1, 0, v_reset(), "rst_mid_hold");
    rst_n = 1'b1;
    step(1, 0, v_reset(), "rst_mid_release");
    step(1, 0, v_fetch(1), "rst_mid_fetch");

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
